// File: rtl/keymap_controls.sv
// Purpose: decodes the {previous, latest} PS/2 keycode pair into debounced per-player
//          direction states with SOCD resolution and typematic move pulses.
// Latency: key_event 1 cycle after keycode changes; move_held/move_pulse 1 cycle later.
// Backpressure: none; keycode is level-held and sampled every cycle, outputs are strobes/levels.
//
// Ports:
//   clk        91 MHz keyboard-domain clock
//   rst        synchronous reset, active-low
//   keycode    {previous byte, latest byte} from top_keyboard, level-held
//   move_held  resolved direction state, bit p*4+d (d: 0=up, 1=down, 2=right, 3=left)
//   move_pulse one-cycle move strobe (initial press, then typematic repeats), bit p*4+d
//   key_event  one-cycle strobe on every decoded make/break, mapped or not
module keymap_controls #(
  parameter int                      NUM_PLAYERS   = 2,
  parameter logic [NUM_PLAYERS*32-1:0] KEYMAP      = {8'h4B, 8'h3B, 8'h42, 8'h43,
                                                      8'h1C, 8'h23, 8'h1B, 8'h1D},
  parameter bit                      SOCD_MODE     = 1'b0,
  parameter int unsigned             DELAY_CYCLES  = 27_300_000,
  parameter int unsigned             PERIOD_CYCLES = 9_100_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              keycode,
  output logic [NUM_PLAYERS*4-1:0] move_held,
  output logic [NUM_PLAYERS*4-1:0] move_pulse,
  output logic                     key_event
);

  localparam int NB = NUM_PLAYERS * 4;  // one bit per player/direction
  localparam int NA = NUM_PLAYERS * 2;  // one flag per player/axis

  localparam int unsigned CNT_MAX = (DELAY_CYCLES > PERIOD_CYCLES) ? DELAY_CYCLES : PERIOD_CYCLES;
  localparam int          CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DLY_LD = CW'(DELAY_CYCLES);
  localparam logic [CW-1:0] PER_LD = CW'(PERIOD_CYCLES);

  logic [15:0]   kc_q;
  logic          armed_q;
  logic [NB-1:0] raw_q,   raw_d;
  logic [NA-1:0] flag_q,  flag_d;   // 1 = second direction of the axis (down/left) made last
  logic [NB-1:0] held_q,  held_d;
  logic [NB-1:0] pulse_q, pulse_d;
  logic          event_q, event_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];

  logic [7:0] lo_byte;
  logic [7:0] hi_byte;

  assign lo_byte = keycode[7:0];
  assign hi_byte = keycode[15:8];

  // Any change of the held pair is a new event, except when the latest byte is
  // itself a break/extended prefix: the real key byte follows on the next change.
  assign event_d = armed_q && (keycode != kc_q) &&
                   (lo_byte != 8'hF0) && (lo_byte != 8'hE0);

  // Raw key state and last-made flags. Bit b = p*4+d lines up with byte b of KEYMAP.
  always_comb begin
    raw_d  = raw_q;
    flag_d = flag_q;
    if (event_d) begin
      for (int b = 0; b < NB; b++) begin
        if (KEYMAP[b*8 +: 8] == lo_byte) begin
          if (hi_byte == 8'hF0) begin
            raw_d[b] = 1'b0;
          end else if (!raw_q[b]) begin
            // typematic re-makes of a held key must not steal the axis flag
            raw_d[b]      = 1'b1;
            flag_d[b / 2] = (b % 2) == 1;
          end
        end
      end
    end
  end

  // SOCD resolution per axis: bits 2a and 2a+1 are the opposite pair.
  always_comb begin
    held_d = '0;
    for (int a = 0; a < NA; a++) begin
      if (SOCD_MODE == 1'b0) begin
        held_d[2*a]   = raw_q[2*a]   & ~raw_q[2*a+1];
        held_d[2*a+1] = raw_q[2*a+1] & ~raw_q[2*a];
      end else if (raw_q[2*a] && raw_q[2*a+1]) begin
        held_d[2*a]   = ~flag_q[a];
        held_d[2*a+1] =  flag_q[a];
      end else begin
        held_d[2*a]   = raw_q[2*a];
        held_d[2*a+1] = raw_q[2*a+1];
      end
    end
  end

  // Typematic engine. The counter counts down to 1 so that pulse spacing equals
  // the programmed value exactly; a zero reload parks it and stops repeats.
  always_comb begin
    pulse_d = '0;
    for (int b = 0; b < NB; b++) begin
      cnt_d[b] = '0;
      if (held_d[b] && !held_q[b]) begin
        pulse_d[b] = 1'b1;
        cnt_d[b]   = DLY_LD;
      end else if (held_d[b]) begin
        if (cnt_q[b] == CW'(1)) begin
          pulse_d[b] = 1'b1;
          cnt_d[b]   = PER_LD;
        end else if (cnt_q[b] != '0) begin
          cnt_d[b] = cnt_q[b] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    kc_q <= keycode;
    if (!rst) begin
      armed_q <= 1'b0;
      raw_q   <= '0;
      flag_q  <= '0;
      held_q  <= '0;
      pulse_q <= '0;
      event_q <= 1'b0;
      for (int b = 0; b < NB; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      armed_q <= 1'b1;
      raw_q   <= raw_d;
      flag_q  <= flag_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      event_q <= event_d;
      for (int b = 0; b < NB; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  assign move_held  = held_q;
  assign move_pulse = pulse_q;
  assign key_event  = event_q;

endmodule

// File: tb/tb_keymap_controls.sv
// Bench for keymap_controls: two instances (cancel and last-wins SOCD) share one
// keycode stream; short repeat timing (delay 10, period 4) keeps runs short.
module tb_keymap_controls;

  localparam int unsigned DLY = 10;
  localparam int unsigned PER = 4;
  localparam logic [63:0] KM  = {8'h4B, 8'h3B, 8'h42, 8'h43, 8'h1C, 8'h23, 8'h1B, 8'h1D};

  logic        clk;
  logic        rst_n;
  logic [15:0] keycode;
  logic [7:0]  held0, pulse0, held1, pulse1;
  logic        ev0, ev1;

  keymap_controls #(.NUM_PLAYERS(2), .KEYMAP(KM), .SOCD_MODE(1'b0),
                    .DELAY_CYCLES(DLY), .PERIOD_CYCLES(PER)) dut0 (
    .clk(clk), .rst(rst_n), .keycode(keycode),
    .move_held(held0), .move_pulse(pulse0), .key_event(ev0));

  keymap_controls #(.NUM_PLAYERS(2), .KEYMAP(KM), .SOCD_MODE(1'b1),
                    .DELAY_CYCLES(DLY), .PERIOD_CYCLES(PER)) dut1 (
    .clk(clk), .rst(rst_n), .keycode(keycode),
    .move_held(held1), .move_pulse(pulse1), .key_event(ev1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference: physical key-down set plus press timestamps; repeats from key age.
  bit          dn    [256];
  int unsigned stamp [256];
  int unsigned seq;
  logic [15:0] m_prev;
  bit          m_armed;
  logic        m_ev;
  logic [7:0]  m_held  [2];
  logic [7:0]  m_pulse [2];
  int unsigned m_age   [2][8];

  typedef struct {
    logic        r;
    logic [15:0] kc;
    logic        ev;
    logic [7:0]  h0, p0, h1, p1;
  } vec_t;

  vec_t       tbl [28];
  logic [7:0] pool [11];

  function automatic vec_t mk(input logic r, input logic [15:0] kc, input logic ev,
                              input logic [7:0] h0, input logic [7:0] p0,
                              input logic [7:0] h1, input logic [7:0] p1);
    vec_t v;
    v.r = r; v.kc = kc; v.ev = ev; v.h0 = h0; v.p0 = p0; v.h1 = h1; v.p1 = p1;
    return v;
  endfunction

  function automatic bit rep_due(input int unsigned age);
    return (age == 0) || (age == DLY) ||
           ((PER != 0) && (age > DLY) && (((age - DLY) % PER) == 0));
  endfunction

  function automatic logic [7:0] resolve(input int mode);
    logic [7:0] r;
    r = '0;
    for (int p = 0; p < 2; p++) begin
      for (int ax = 0; ax < 2; ax++) begin
        logic [7:0] ca, cb;
        bit pa, pb, oa, ob;
        ca = KM[p*32 + ax*16 +: 8];
        cb = KM[p*32 + ax*16 + 8 +: 8];
        pa = dn[ca];
        pb = dn[cb];
        if (mode == 0) begin
          oa = pa && !pb;
          ob = pb && !pa;
        end else if (pa && pb) begin
          oa = stamp[ca] > stamp[cb];
          ob = !oa;
        end else begin
          oa = pa;
          ob = pb;
        end
        r[p*4 + ax*2]     = oa;
        r[p*4 + ax*2 + 1] = ob;
      end
    end
    return r;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      for (int c = 0; c < 256; c++) dn[c] = 1'b0;
      m_armed = 1'b0;
      m_ev    = 1'b0;
      for (int m = 0; m < 2; m++) begin
        m_held[m]  = '0;
        m_pulse[m] = '0;
        for (int b = 0; b < 8; b++) m_age[m][b] = 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        logic [7:0] nh;
        nh = resolve(m);
        for (int b = 0; b < 8; b++) begin
          if (nh[b] && !m_held[m][b]) m_age[m][b] = 0;
          else if (nh[b])             m_age[m][b] = m_age[m][b] + 1;
          m_pulse[m][b] = nh[b] && rep_due(m_age[m][b]);
        end
        m_held[m] = nh;
      end
      m_ev = 1'b0;
      if (m_armed && keycode != m_prev &&
          keycode[7:0] != 8'hF0 && keycode[7:0] != 8'hE0) begin
        m_ev = 1'b1;
        if (keycode[15:8] == 8'hF0) begin
          dn[keycode[7:0]] = 1'b0;
        end else if (!dn[keycode[7:0]]) begin
          dn[keycode[7:0]]    = 1'b1;
          seq                 = seq + 1;
          stamp[keycode[7:0]] = seq;
        end
      end
      m_armed = 1'b1;
    end
    m_prev = keycode;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [15:0] k);
    rst_n   = r;
    keycode = k;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    chk("mdl_event_m0", {7'b0, ev0}, {7'b0, m_ev});
    chk("mdl_event_m1", {7'b0, ev1}, {7'b0, m_ev});
    chk("mdl_held_m0",  held0,  m_held[0]);
    chk("mdl_held_m1",  held1,  m_held[1]);
    chk("mdl_pulse_m0", pulse0, m_pulse[0]);
    chk("mdl_pulse_m1", pulse1, m_pulse[1]);
  endtask

  initial begin
    rst_n   = 1'b0;
    keycode = 16'h001D;
    seq     = 0;
    m_prev  = '0;
    for (int c = 0; c < 256; c++) begin
      dn[c]    = 1'b0;
      stamp[c] = 0;
    end

    //               r     kc        ev    h0     p0     h1     p1
    tbl[0]  = mk(1'b0, 16'h001D, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(1'b0, 16'h001D, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[2]  = mk(1'b1, 16'h001D, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);  // arming edge
    tbl[3]  = mk(1'b1, 16'h001D, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[4]  = mk(1'b1, 16'h1D1B, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);  // make S
    tbl[5]  = mk(1'b1, 16'h1D1B, 1'b0, 8'h02, 8'h02, 8'h02, 8'h02);
    tbl[6]  = mk(1'b1, 16'h1D1B, 1'b0, 8'h02, 8'h00, 8'h02, 8'h00);
    tbl[7]  = mk(1'b1, 16'h1BF0, 1'b0, 8'h02, 8'h00, 8'h02, 8'h00);  // prefix only
    tbl[8]  = mk(1'b1, 16'hF01B, 1'b1, 8'h02, 8'h00, 8'h02, 8'h00);  // break S
    tbl[9]  = mk(1'b1, 16'hF01B, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[10] = mk(1'b1, 16'h001D, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);  // make W
    tbl[11] = mk(1'b1, 16'h001D, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01);
    tbl[12] = mk(1'b1, 16'h001B, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00);  // make S, W held
    tbl[13] = mk(1'b1, 16'h001B, 1'b0, 8'h00, 8'h00, 8'h02, 8'h02);
    tbl[14] = mk(1'b1, 16'h1BF0, 1'b0, 8'h00, 8'h00, 8'h02, 8'h00);
    tbl[15] = mk(1'b1, 16'hF01B, 1'b1, 8'h00, 8'h00, 8'h02, 8'h00);  // break S
    tbl[16] = mk(1'b1, 16'hF01B, 1'b0, 8'h01, 8'h01, 8'h01, 8'h01);
    tbl[17] = mk(1'b1, 16'hF01B, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
    tbl[18] = mk(1'b1, 16'h1DF0, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00);
    tbl[19] = mk(1'b1, 16'hF01D, 1'b1, 8'h01, 8'h00, 8'h01, 8'h00);  // break W
    tbl[20] = mk(1'b1, 16'hF01D, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[21] = mk(1'b1, 16'h0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);  // unmapped make
    tbl[22] = mk(1'b1, 16'hE075, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);  // extended unmapped
    tbl[23] = mk(1'b1, 16'h0023, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);  // make D
    tbl[24] = mk(1'b1, 16'h0023, 1'b0, 8'h04, 8'h04, 8'h04, 8'h04);
    tbl[25] = mk(1'b0, 16'h0023, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);  // reset while held
    tbl[26] = mk(1'b1, 16'h0023, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[27] = mk(1'b1, 16'h0023, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 28; i++) begin
      step(tbl[i].r, tbl[i].kc);
      chk("tbl_event",    {7'b0, ev0}, {7'b0, tbl[i].ev});
      chk("tbl_held_m0",  held0,  tbl[i].h0);
      chk("tbl_pulse_m0", pulse0, tbl[i].p0);
      chk("tbl_held_m1",  held1,  tbl[i].h1);
      chk("tbl_pulse_m1", pulse1, tbl[i].p1);
    end

    // Typematic on P1 left (4B, bit 7): pulses at ages 0,10,14,18,22,26,30.
    step(1'b1, 16'h004B);
    chk("rep_press_event", {7'b0, ev0}, 8'h01);
    for (int k = 0; k < 31; k++) begin
      logic [7:0] ep;
      ep = (k == 0 || k == 10 || k == 14 || k == 18 || k == 22 || k == 26 || k == 30)
           ? 8'h80 : 8'h00;
      step(1'b1, (k == 30) ? 16'hF04B : 16'h004B);
      chk("rep_pulse_m0", pulse0, ep);
      chk("rep_pulse_m1", pulse1, ep);
      chk("rep_held_m0",  held0,  8'h80);
    end
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 16'hF04B);
      chk("rel_pulse", pulse0, 8'h00);
      chk("rel_held",  held0,  8'h00);
    end

    // Reset in the middle of a repeat on P0 right (23).
    step(1'b1, 16'h0023);
    for (int k = 0; k < 12; k++) step(1'b1, 16'h0023);
    chk("pre_rst_held", held0, 8'h04);
    step(1'b0, 16'h0023);
    chk("rst_held",  held0,  8'h00);
    chk("rst_pulse", pulse0, 8'h00);
    chk("rst_event", {7'b0, ev0}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 16'h0023);
      chk("post_rst_event", {7'b0, ev1}, 8'h00);
      chk("post_rst_held",  held1, 8'h00);
    end
    step(1'b1, 16'hF023);
    chk("post_rst_change_event", {7'b0, ev0}, 8'h01);

    // Random keycode stream against the reference.
    pool = '{8'h1D, 8'h1B, 8'h23, 8'h1C, 8'h43, 8'h42, 8'h3B, 8'h4B, 8'h29, 8'hF0, 8'hE0};
    for (int s = 0; s < 450; s++) begin
      logic [7:0]  lo, hi;
      int unsigned sel, len;
      lo  = pool[$urandom_range(0, 10)];
      sel = $urandom_range(0, 3);
      hi  = (sel < 2) ? 8'hF0 : ((sel == 2) ? 8'h00 : 8'hE0);
      len = $urandom_range(1, 16);
      if ($urandom_range(0, 39) == 0) begin
        step(1'b0, {hi, lo});
      end
      for (int l = 0; l < int'(len); l++) step(1'b1, {hi, lo});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
